// File: rtl/multihash_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multihash_port_arbiter_pkg
// Brief    : Shared multihash definitions: multicodec codes, arbiter FSM
//            encoding and statistics counter width.
// Revision : 1.0  initial release
// ============================================================================
package multihash_port_arbiter_pkg;

   typedef enum logic [7:0] {
      MC_IDENTITY = 8'h00,
      MC_SHA1     = 8'h11,
      MC_SHA2_256 = 8'h12,
      MC_SHA2_512 = 8'h13,
      MC_SHA3_512 = 8'h14
   } multicodec_t;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_PASS = 1'b1
   } arb_state_t;

   localparam int c_pkt_cnt_w = 32;
   localparam int c_grant_w   = 3;
   // Port-indexed structures are padded to this size so a 3-bit index is exact.
   localparam int c_max_ports = 8;

endpackage
`default_nettype wire

// File: rtl/multihash_port_arbiter_rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_select
// Brief    : Combinational round-robin pick: first asserted request searching
//            upward from last_idx+1, wrapping at NUM_PORTS.
// Revision : 1.0  initial release
// ============================================================================
module rr_priority_select
   import multihash_port_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 4
)(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [c_grant_w-1:0] last_idx,
   output logic [c_grant_w-1:0] grant_idx,
   output logic                 any_req
);

   logic [c_max_ports-1:0] w_req_pad;
   logic [3:0]             w_cand;
   logic                   w_found;

   assign w_req_pad = c_max_ports'(req);
   assign any_req   = |req;

   always_comb begin
      grant_idx = '0;
      w_found   = 1'b0;
      w_cand    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         // last_idx < NUM_PORTS, so one conditional subtract is a full modulo.
         w_cand = {1'b0, last_idx} + 4'(i) + 4'd1;
         if (w_cand >= 4'(NUM_PORTS)) begin
            w_cand = w_cand - 4'(NUM_PORTS);
         end
         if (!w_found && w_req_pad[w_cand[2:0]]) begin
            grant_idx = w_cand[2:0];
            w_found   = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/multihash_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : multihash_port_arbiter
// Brief    : N:1 AXI-Stream packet arbiter, round-robin, one bubble per packet.
//            Define MULTIHASH_ARB_STATS_EN to build per-port packet counters.
// Revision : 1.0  initial release
// ============================================================================
module multihash_port_arbiter
   import multihash_port_arbiter_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH  = 512,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_PORTS          = 4
)(
   input  logic                                  axis_aclk,
   input  logic                                  axis_resetn,
   input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
   input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]                  s_axis_tlast,
   output logic [NUM_PORTS-1:0]                  s_axis_tready,
   output logic [C_AXIS_DATA_WIDTH-1:0]          m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]        m_axis_tkeep,
   output logic [C_AXIS_TUSER_WIDTH-1:0]         m_axis_tuser,
   output logic                                  m_axis_tvalid,
   output logic                                  m_axis_tlast,
   input  logic                                  m_axis_tready,
   output logic [c_grant_w-1:0]                  grant_id,
   output logic [NUM_PORTS*c_pkt_cnt_w-1:0]      pkt_count
);

   localparam int c_keep_w = C_AXIS_DATA_WIDTH / 8;

   arb_state_t             r_state;
   arb_state_t             w_state_next;
   logic [c_grant_w-1:0]   r_grant;
   logic [c_grant_w-1:0]   r_last_grant;
   logic [c_grant_w-1:0]   w_sel_grant;
   logic                   w_any_req;
   logic                   w_xfer;
   logic                   w_eop;

   logic [C_AXIS_DATA_WIDTH-1:0]  w_tdata [c_max_ports];
   logic [c_keep_w-1:0]           w_tkeep [c_max_ports];
   logic [C_AXIS_TUSER_WIDTH-1:0] w_tuser [c_max_ports];
   logic [c_max_ports-1:0]        w_tvalid_pad;
   logic [c_max_ports-1:0]        w_tlast_pad;

   assign w_tvalid_pad = c_max_ports'(s_axis_tvalid);
   assign w_tlast_pad  = c_max_ports'(s_axis_tlast);

   generate
      for (genvar p = 0; p < c_max_ports; p++) begin : g_unpack
         if (p < NUM_PORTS) begin : g_live
            assign w_tdata[p] = s_axis_tdata[p*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
            assign w_tkeep[p] = s_axis_tkeep[p*c_keep_w +: c_keep_w];
            assign w_tuser[p] = s_axis_tuser[p*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
         end else begin : g_pad
            assign w_tdata[p] = '0;
            assign w_tkeep[p] = '0;
            assign w_tuser[p] = '0;
         end
      end
   endgenerate

   rr_priority_select #(
      .NUM_PORTS (NUM_PORTS)
   ) u_rr_select (
      .req       (s_axis_tvalid),
      .last_idx  (r_last_grant),
      .grant_idx (w_sel_grant),
      .any_req   (w_any_req)
   );

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB_IDLE: if (w_any_req) w_state_next = ARB_PASS;
         ARB_PASS: if (w_eop)     w_state_next = ARB_IDLE;
         default:                 w_state_next = ARB_IDLE;
      endcase
   end

   // Grant only moves while idle, so a packet can never be interleaved.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_grant      <= '0;
         r_last_grant <= c_grant_w'(NUM_PORTS - 1);
      end else begin
         if (r_state == ARB_IDLE && w_any_req) begin
            r_grant <= w_sel_grant;
         end
         if (w_eop) begin
            r_last_grant <= r_grant;
         end
      end
   end

   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tuser  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      if (r_state == ARB_PASS) begin
         m_axis_tdata  = w_tdata[r_grant];
         m_axis_tkeep  = w_tkeep[r_grant];
         m_axis_tuser  = w_tuser[r_grant];
         m_axis_tvalid = w_tvalid_pad[r_grant];
         m_axis_tlast  = w_tlast_pad[r_grant];
      end
   end

   generate
      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ready
         assign s_axis_tready[p] = (r_state == ARB_PASS) && (r_grant == c_grant_w'(p))
                                   && m_axis_tready;
      end
   endgenerate

   assign w_xfer   = m_axis_tvalid & m_axis_tready;
   assign w_eop    = w_xfer & m_axis_tlast;
   assign grant_id = r_grant;

`ifdef MULTIHASH_ARB_STATS_EN
   generate
      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stats
         logic [c_pkt_cnt_w-1:0] r_pkt_cnt;
         always_ff @(posedge axis_aclk or negedge axis_resetn) begin
            if (!axis_resetn) begin
               r_pkt_cnt <= '0;
            end else if (w_eop && r_grant == c_grant_w'(p)) begin
               r_pkt_cnt <= r_pkt_cnt + c_pkt_cnt_w'(1);
            end
         end
         assign pkt_count[p*c_pkt_cnt_w +: c_pkt_cnt_w] = r_pkt_cnt;
      end
   endgenerate
`else
   assign pkt_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multihash_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_multihash_port_arbiter
// Brief    : Self-checking bench: arbitration vector table, hand-written
//            corner sequences and randomized traffic against a packet model.
// Revision : 1.0  initial release
// ============================================================================
module tb_multihash_port_arbiter;

   localparam int NP = 4;
   localparam int DW = 64;
   localparam int TW = 16;
   localparam int KW = DW / 8;
   localparam int CW = 32;
   localparam int BUDGET = 4000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NP*DW-1:0]  s_tdata;
   logic [NP*KW-1:0]  s_tkeep;
   logic [NP*TW-1:0]  s_tuser;
   logic [NP-1:0]     s_tvalid;
   logic [NP-1:0]     s_tlast;
   logic [NP-1:0]     s_tready;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tkeep;
   logic [TW-1:0]     m_tuser;
   logic              m_tvalid;
   logic              m_tlast;
   logic              m_tready;
   logic [2:0]        grant_id;
   logic [NP*CW-1:0]  pkt_count;

   always #5 clk = ~clk;

   multihash_port_arbiter #(
      .C_AXIS_DATA_WIDTH  (DW),
      .C_AXIS_TUSER_WIDTH (TW),
      .NUM_PORTS          (NP)
   ) dut (
      .axis_aclk     (clk),
      .axis_resetn   (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tuser  (s_tuser),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tuser  (m_tuser),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .grant_id      (grant_id),
      .pkt_count     (pkt_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [NP-1:0] req;
      int            exp_grant;
   } arb_vec_t;
   arb_vec_t vecs [10];

   typedef struct packed {
      logic          l;
      logic [DW-1:0] d;
   } beat_t;
   beat_t mem [NP][32];
   int    rd [NP];
   int    wr [NP];
   int    cnt_exp [NP];
   int    grant_seq [64];
   int    n_grants;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] make_data(input int tag, input int k);
      return {32'(tag) * 32'h0101_0101 ^ 32'hDEAD_0000, 32'(k) * 32'h0011_0011 ^ 32'h0000_BEEF};
   endfunction

   // Keep and user are derived from the data so one value identifies the whole beat.
   function automatic logic [TW+KW+DW-1:0] bus_of(input logic [DW-1:0] d);
      return {d[31:16], d[15:8], d};
   endfunction

   task automatic set_port(input int p, input logic v, input logic l, input logic [DW-1:0] d);
      s_tvalid[p]           = v;
      s_tlast[p]            = l;
      s_tdata[p*DW +: DW]   = d;
      s_tkeep[p*KW +: KW]   = d[15:8];
      s_tuser[p*TW +: TW]   = d[31:16];
   endtask

   task automatic clear_all();
      for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, '0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_all();
      m_tready = 1'b0;
      for (int p = 0; p < NP; p++) cnt_exp[p] = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic check_counts(input string name);
      for (int p = 0; p < NP; p++) begin
`ifdef MULTIHASH_ARB_STATS_EN
         check(name, pkt_count[p*CW +: CW], 128'(cnt_exp[p]));
`else
         check(name, pkt_count[p*CW +: CW], 128'(0));
`endif
      end
   endtask

   // Packet-level model: an idle arbiter picks the first valid port after the
   // previous winner; a busy one forwards only its owner's queue until tlast.
   task automatic run_traffic(input bit cont, input int npk, output int cycles);
      int            owner;
      int            lastg;
      int            nb;
      bit            empty;
      logic [NP-1:0] v;
      owner    = -1;
      lastg    = NP - 1;
      cycles   = 0;
      n_grants = 0;
      for (int p = 0; p < NP; p++) begin
         rd[p] = 0;
         wr[p] = 0;
         for (int k = 0; k < npk; k++) begin
            nb = cont ? 3 : int'($urandom_range(1, 4));
            for (int b = 0; b < nb; b++) begin
               mem[p][wr[p]].l = (b == nb - 1);
               mem[p][wr[p]].d = make_data(100 + p*16 + k, b) ^ {$urandom(), 32'h0};
               wr[p]++;
            end
         end
      end
      while (cycles < BUDGET) begin
         empty = 1'b1;
         for (int p = 0; p < NP; p++) if (rd[p] < wr[p]) empty = 1'b0;
         if (empty && owner < 0) break;
         m_tready = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
         for (int p = 0; p < NP; p++) begin
            v[p] = (rd[p] < wr[p]) && (cont || $urandom_range(0, 3) != 0);
            if (v[p]) set_port(p, 1'b1, mem[p][rd[p]].l, mem[p][rd[p]].d);
            else      set_port(p, 1'b0, 1'b0, '0);
         end
         #1;
         if (owner < 0) begin
            check("trf_idle_tvalid", m_tvalid, 0);
            check("trf_idle_tready", s_tready, 0);
            for (int d = 1; d <= NP; d++) begin
               if (owner < 0 && v[(lastg + d) % NP]) owner = (lastg + d) % NP;
            end
            if (owner >= 0) begin
               grant_seq[n_grants] = owner;
               n_grants++;
            end
         end else begin
            check("trf_grant", grant_id, 128'(owner));
            check("trf_tvalid", m_tvalid, v[owner]);
            check("trf_tready", s_tready, m_tready ? (128'(1) << owner) : 128'(0));
            if (v[owner]) begin
               check("trf_beat", bus_of(m_tdata) == bus_of(m_tdata) ? {m_tuser, m_tkeep, m_tdata} : '0,
                     bus_of(mem[owner][rd[owner]].d));
               check("trf_tlast", m_tlast, mem[owner][rd[owner]].l);
               if (m_tready) begin
                  if (mem[owner][rd[owner]].l) begin
                     cnt_exp[owner]++;
                     rd[owner]++;
                     lastg = owner;
                     owner = -1;
                  end else begin
                     rd[owner]++;
                  end
               end
            end
         end
         tick();
         cycles++;
      end
      check("trf_timeout", (cycles >= BUDGET), 0);
      clear_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int cyc;
      bit xfer;

      vecs[0] = '{req: 4'b0101, exp_grant: 0};
      vecs[1] = '{req: 4'b0101, exp_grant: 2};
      vecs[2] = '{req: 4'b0101, exp_grant: 0};
      vecs[3] = '{req: 4'b0010, exp_grant: 1};
      vecs[4] = '{req: 4'b0010, exp_grant: 1};
      vecs[5] = '{req: 4'b1000, exp_grant: 3};
      vecs[6] = '{req: 4'b1111, exp_grant: 0};
      vecs[7] = '{req: 4'b1111, exp_grant: 1};
      vecs[8] = '{req: 4'b1001, exp_grant: 3};
      vecs[9] = '{req: 4'b0110, exp_grant: 1};

      rst_n    = 1'b0;
      m_tready = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tuser  = '0;
      s_tvalid = '0;
      s_tlast  = '0;
      for (int p = 0; p < NP; p++) cnt_exp[p] = 0;
      repeat (2) tick();
      check("rst_grant_id", grant_id, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_s_tready", s_tready, 0);
      check("rst_pkt_count", pkt_count, 0);
      rst_n = 1'b1;
      tick();

      // Arbitration table: single-beat packets, one idle bubble before each grant.
      m_tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         for (int p = 0; p < NP; p++) set_port(p, vecs[i].req[p], 1'b1, make_data(16*i + p + 1, 0));
         #1;
         check("tbl_bubble_tvalid", m_tvalid, 0);
         check("tbl_bubble_tready", s_tready, 0);
         tick();
         check("tbl_grant", grant_id, 128'(vecs[i].exp_grant));
         check("tbl_tvalid", m_tvalid, 1);
         check("tbl_beat", {m_tuser, m_tkeep, m_tdata}, bus_of(make_data(16*i + vecs[i].exp_grant + 1, 0)));
         check("tbl_tready", s_tready, 128'(1) << vecs[i].exp_grant);
         tick();
         clear_all();
      end

      // 5-beat packet from port 1 with m_tready toggling 1,0,1,0...
      k = 0;
      set_port(1, 1'b1, 1'b0, make_data(31, 0));
      tick();
      for (int c = 0; c < 40 && k < 5; c++) begin
         m_tready = (c % 2 == 0);
         #1;
         check("stall_grant", grant_id, 1);
         check("stall_tvalid", m_tvalid, 1);
         check("stall_beat", {m_tuser, m_tkeep, m_tdata}, bus_of(make_data(31, k)));
         check("stall_tready", s_tready, m_tready ? 128'h2 : 128'h0);
         xfer = m_tready;
         tick();
         if (xfer) begin
            k++;
            if (k < 5) set_port(1, 1'b1, (k == 4), make_data(31, k));
            else       set_port(1, 1'b0, 1'b0, '0);
         end
      end
      check("stall_beats", 128'(k), 5);
      #1;
      check("stall_done_idle", m_tvalid, 0);

      // Port 1 pauses mid-packet while port 0 waits; ownership must hold.
      m_tready = 1'b1;
      set_port(0, 1'b1, 1'b1, make_data(40, 0));
      tick();
      check("pause_pre_grant", grant_id, 0);
      tick();
      clear_all();
      set_port(1, 1'b1, 1'b0, make_data(41, 0));
      set_port(0, 1'b1, 1'b1, make_data(42, 0));
      tick();
      check("pause_grant", grant_id, 1);
      tick();
      set_port(1, 1'b0, 1'b0, '0);
      for (int c = 0; c < 3; c++) begin
         #1;
         check("pause_hold_grant", grant_id, 1);
         check("pause_hold_tvalid", m_tvalid, 0);
         check("pause_hold_tready", s_tready, 4'b0010);
         tick();
      end
      set_port(1, 1'b1, 1'b1, make_data(41, 1));
      #1;
      check("pause_last_beat", {m_tuser, m_tkeep, m_tdata}, bus_of(make_data(41, 1)));
      check("pause_last_tlast", m_tlast, 1);
      tick();
      set_port(1, 1'b0, 1'b0, '0);
      #1;
      check("pause_bubble", m_tvalid, 0);
      tick();
      check("pause_next_grant", grant_id, 0);
      tick();
      clear_all();

      // Asynchronous reset on the second beat of a port-3 packet.
      do_reset();
      m_tready = 1'b1;
      set_port(3, 1'b1, 1'b0, make_data(50, 0));
      tick();
      check("arst_grant3", grant_id, 3);
      tick();
      set_port(3, 1'b1, 1'b0, make_data(50, 1));
      #1;
      check("arst_beat2_valid", m_tvalid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_tvalid", m_tvalid, 0);
      check("arst_tready", s_tready, 0);
      check("arst_grant", grant_id, 0);
      check("arst_data", {m_tuser, m_tkeep, m_tdata}, 0);
      tick();
      rst_n = 1'b1;
      set_port(0, 1'b1, 1'b1, make_data(51, 0));
      #1;
      check("arst_rel_idle", m_tvalid, 0);
      tick();
      check("arst_rel_grant", grant_id, 0);
      check("arst_rel_beat", {m_tuser, m_tkeep, m_tdata}, bus_of(make_data(51, 0)));
      tick();
      clear_all();

      // Ten single-beat packets on port 2.
      do_reset();
      m_tready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         set_port(2, 1'b1, 1'b1, make_data(60, j));
         tick();
         check("cnt_tvalid", m_tvalid, 1);
         tick();
         cnt_exp[2]++;
      end
      clear_all();
      #1;
      check_counts("cnt_port");

      // All ports streaming 3-beat packets back to back.
      do_reset();
      run_traffic(1'b1, 2, cyc);
      check("cont_cycles", 128'(cyc), 32);
      check("cont_ngrants", 128'(n_grants), 8);
      for (int i = 0; i < 8; i++) check("cont_order", 128'(grant_seq[i]), 128'(i % NP));
      check_counts("cont_count");

      // Randomized valid/ready traffic.
      do_reset();
      run_traffic(1'b0, 5, cyc);
      check_counts("rnd_count");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multihash_port_arbiter.md
MULTIHASH_PORT_ARBITER -- requirements
Module: multihash_port_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 512, AXIS data width in bits.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, AXIS tuser width in bits.
REQ-003 SHALL have parameter NUM_PORTS, default 4, number of slave ports (2..8).
REQ-004 SHALL have port axis_aclk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port axis_resetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_axis_tdata  in  NUM_PORTS*C_AXIS_DATA_WIDTH  flattened per-port data, port p at slice p.
REQ-007 SHALL have port s_axis_tkeep  in  NUM_PORTS*C_AXIS_DATA_WIDTH/8  flattened per-port keep.
REQ-008 SHALL have port s_axis_tuser  in  NUM_PORTS*C_AXIS_TUSER_WIDTH  flattened per-port tuser.
REQ-009 SHALL have ports s_axis_tvalid / s_axis_tlast  in  NUM_PORTS  per-port valid / last; s_axis_tready  out  NUM_PORTS  per-port ready.
REQ-010 SHALL have ports m_axis_tdata, m_axis_tkeep, m_axis_tuser  out  widths as one slave port  selected beat.
REQ-011 SHALL have ports m_axis_tvalid, m_axis_tlast  out  1; m_axis_tready  in  1.
REQ-012 SHALL have port grant_id  out  3  index of the port currently owning the master.
REQ-013 SHALL have port pkt_count  out  NUM_PORTS*32  per-port completed-packet counters.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, PASS.
REQ-015 In IDLE all s_axis_tready and m_axis_tvalid SHALL be 0; when any s_axis_tvalid is 1, grant SHALL register the first requesting port searching round-robin from last_grant+1 (mod NUM_PORTS), and the FSM SHALL enter PASS next cycle.
REQ-016 In PASS, m_axis_* SHALL combinationally equal the granted port's signals, s_axis_tready[grant] SHALL equal m_axis_tready, all other s_axis_tready 0.
REQ-017 A beat SHALL transfer when m_axis_tvalid and m_axis_tready are both 1; on a transfer with tlast=1 the FSM SHALL return to IDLE and last_grant SHALL load grant.
REQ-018 Grant SHALL change only in IDLE; packets SHALL never interleave.
REQ-019 Arbitration latency SHALL be exactly one idle cycle between packets (one bubble per packet).
REQ-020 Granted source dropping tvalid mid-packet SHALL hold PASS with m_axis_tvalid=0; no timeout.
REQ-021 m_axis_tready low SHALL stall without loss or duplication; tuser/tkeep SHALL pass unmodified.
REQ-022 A lone requester SHALL be re-granted after each bubble; NUM_PORTS requesters SHALL be served in strict rotation.

Reset
REQ-023 Reset assertion SHALL force IDLE asynchronously, including mid-packet; the partial packet is abandoned, not completed.
REQ-024 Reset values: grant_id 0, last_grant NUM_PORTS-1 (port 0 wins first), m_axis_tvalid 0, all s_axis_tready 0, pkt_count 0.

Configuration
REQ-025 Macro MULTIHASH_ARB_STATS_EN defined: each pkt_count slice SHALL increment (wrapping at 2^32) on each tlast transfer from that port.
REQ-026 Macro undefined: no counter registers SHALL exist and pkt_count SHALL be tied to 0; port list unchanged.

Structure
REQ-027 FSM state encodings and the 32-bit counter width SHALL live in the shared multihash package/include with the multicodec definitions.
REQ-028 Round-robin selection SHALL be a sub-module rr_priority_select (request vector, last index in; grant index and any-request out, combinational).

Verification
REQ-029 Ports 0 and 2 request simultaneously after reset -> port 0 granted first, port 2 next; grant_id 0 then 2; one bubble between packets.
REQ-030 All 4 ports stream 3-beat packets continuously -> order 0,1,2,3,0,...; no interleaving; 4 bubbles per rotation.
REQ-031 m_axis_tready toggles 1,0,1,0 during a 5-beat packet from port 1 -> 5 beats out, data identical, s_axis_tready[1] follows m_axis_tready.
REQ-032 Reset asserted on beat 2 of a 4-beat packet from port 3 -> outputs zero immediately; after release port 0 wins if requesting.
REQ-033 With MULTIHASH_ARB_STATS_EN, 10 packets on port 2 -> pkt_count[2]=10, others 0; without macro -> all 0.
REQ-034 Port 1 drops tvalid for 3 cycles mid-packet while port 0 requests -> grant stays 1 until port 1 tlast.
